// File: rtl/arm_lsu.sv
// arm_lsu - load/store unit between the memory-access stage and the
// big-endian, word-only arm_memory data port.
//
// Each accepted request does one aligned word read. Loads extract and extend
// the addressed lane. Stores always read first, merge the new lane(s) into the
// word, and then write the full word back. Faults are reported with done.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req / ready       request handshake (ready only in IDLE)
//   rw, size,         request: 0 load / 1 store, 00 byte / 01 half /
//   signed_ld,        10 word / 11 illegal, sign-extend sub-word loads,
//   addr, wdata       byte address, right-justified store data
//   done              one-cycle completion pulse
//   rdata             load result (0 for stores and faults)
//   fault, fault_code 00 none, 01 misaligned, 10 memory exception, 11 size
//   mem_addr          word-aligned address to arm_memory
//   mem_wdata, mem_we merged write word and write enable to arm_memory
//   mem_rdata         combinational read data from arm_memory
//   mem_excpt         combinational region exception from arm_memory
module arm_lsu #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        signed_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_excpt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_MEM      = 2'b10;
  localparam logic [1:0] FC_SIZE     = 2'b11;

  state_t      state;
  logic        lat_rw;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] merged_q;

  logic        misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Control outputs come straight from the state register, so an
  // asynchronous reset drops mem_we before the next edge can write.
  assign ready     = (state == IDLE);
  assign done      = (state == RESP);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = {lat_addr[31:2], 2'b00};
  assign mem_wdata = merged_q;

  // Alignment is judged on the incoming request, before it is latched.
  always_comb begin
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  end

  // Lane selection on the big-endian word: byte k lives at [31-8k:24-8k],
  // the halfword at [31:16] for addr[1]=0 and [15:0] for addr[1]=1.
  // addr[0] is ignored for halfwords, which gives the force-aligned
  // behaviour when ALIGN_CHECK is 0.
  always_comb begin
    lane_b     = 8'h00;
    lane_h     = 16'h0000;
    load_data  = mem_rdata;
    merge_data = lat_wdata;
    case (lat_size)
      SZ_BYTE: begin
        merge_data = mem_rdata;
        case (lat_addr[1:0])
          2'd0: begin lane_b = mem_rdata[31:24]; merge_data[31:24] = lat_wdata[7:0]; end
          2'd1: begin lane_b = mem_rdata[23:16]; merge_data[23:16] = lat_wdata[7:0]; end
          2'd2: begin lane_b = mem_rdata[15:8];  merge_data[15:8]  = lat_wdata[7:0]; end
          default: begin lane_b = mem_rdata[7:0]; merge_data[7:0] = lat_wdata[7:0]; end
        endcase
        load_data = {{24{lat_signed & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        merge_data = mem_rdata;
        if (lat_addr[1]) begin
          lane_h           = mem_rdata[15:0];
          merge_data[15:0] = lat_wdata[15:0];
        end else begin
          lane_h            = mem_rdata[31:16];
          merge_data[31:16] = lat_wdata[15:0];
        end
        load_data = {{16{lat_signed & lane_h[15]}}, lane_h};
      end
      default: begin
        load_data  = mem_rdata;
        merge_data = lat_wdata;
      end
    endcase
  end

  // Main FSM. rdata/fault/fault_code are only written on the transition
  // into RESP so they hold their last result until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_rw     <= 1'b0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      merged_q   <= 32'h0;
      rdata      <= 32'h0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_rw     <= rw;
            lat_size   <= size;
            lat_signed <= signed_ld;
            lat_addr   <= addr;
            lat_wdata  <= wdata;
            if (size == SZ_ILLEGAL) begin
              state      <= RESP;
              rdata      <= 32'h0;
              fault      <= 1'b1;
              fault_code <= FC_SIZE;
            end else if (ALIGN_CHECK && misaligned) begin
              state      <= RESP;
              rdata      <= 32'h0;
              fault      <= 1'b1;
              fault_code <= FC_MISALIGN;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // Word stores also take this read so every access gets the
          // same region check before anything is written.
          if (mem_excpt) begin
            state      <= RESP;
            rdata      <= 32'h0;
            fault      <= 1'b1;
            fault_code <= FC_MEM;
          end else if (!lat_rw) begin
            state      <= RESP;
            rdata      <= load_data;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end else begin
            state    <= WRITE;
            merged_q <= merge_data;
          end
        end
        WRITE: begin
          state      <= RESP;
          rdata      <= 32'h0;
          fault      <= 1'b0;
          fault_code <= FC_NONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_lsu.sv
// tb_arm_lsu - directed bench for arm_lsu.
//
// A transaction-level model predicts, for each request, the completion cycle,
// the result and the memory write it must cause. One compare process checks
// the DUT against that prediction on every cycle. A second instance with
// ALIGN_CHECK = 0 is driven in parallel for the force-aligned case.
module tb_arm_lsu;

  logic        clk;
  logic        reset;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        signed_ld;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ready, done, fault, mem_we, mem_excpt;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  fault_code;

  logic        ready1, done1, fault1, mem_we1, mem_excpt1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [1:0]  fault_code1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          acc_cyc;
    int          done_cyc;
    int          we_cyc;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  code;
    logic [31:0] we_addr;
    logic [31:0] we_data;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] model_mem [logic [31:0]];

  logic [31:0] mem_arr [0:15];
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [31:0] bd_data;

  int          done_count = 0;
  int          last_done_cyc = -1;
  logic [31:0] last_rdata;
  logic        last_fault;
  logic [1:0]  last_code;
  int          we_count = 0;
  int          last_we_cyc = -1;
  logic [31:0] last_we_addr;
  logic [31:0] last_we_data;
  int          last1_done_cyc = -1;
  logic [31:0] last1_rdata;
  logic        last1_fault;

  arm_lsu dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready), .rw(rw), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .done(done),
    .rdata(rdata), .fault(fault), .fault_code(fault_code),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_excpt(mem_excpt)
  );

  arm_lsu #(.ALIGN_CHECK(1'b0)) dut_noalign (
    .clk(clk), .reset(reset), .req(req), .ready(ready1), .rw(rw), .size(size),
    .signed_ld(signed_ld), .addr(addr), .wdata(wdata), .done(done1),
    .rdata(rdata1), .fault(fault1), .fault_code(fault_code1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
    .mem_rdata(mem_rdata1), .mem_excpt(mem_excpt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench memory: region 0x1000xxxx, 16 words; only the main DUT may write.
  assign mem_excpt  = (mem_addr[31:16] != 16'h1000);
  assign mem_rdata  = mem_arr[mem_addr[5:2]];
  assign mem_excpt1 = (mem_addr1[31:16] != 16'h1000);
  assign mem_rdata1 = mem_arr[mem_addr1[5:2]];

  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_addr[5:2]] <= bd_data;
    else if (mem_we && !mem_excpt) mem_arr[mem_addr[5:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model of one request, from the access rules: pick the lane by byte
  // offset and width, shift/mask arithmetically, predict the timing.
  function automatic exp_t model_req(input logic rw_i, input logic [1:0] size_i,
                                     input logic sgn_i, input logic [31:0] addr_i,
                                     input logic [31:0] wdata_i, input int acc,
                                     input bit align);
    exp_t e;
    int nbytes, off, shift;
    logic [31:0] wa, word, lmask, mask, val;
    e.acc_cyc = acc;
    e.we_cyc  = -1;
    e.rdata   = 32'h0;
    e.fault   = 1'b0;
    e.code    = 2'b00;
    e.we_addr = 32'h0;
    e.we_data = 32'h0;
    nbytes = (size_i == 2'b00) ? 1 : (size_i == 2'b01) ? 2 : 4;
    if (size_i == 2'b11) begin
      e.fault = 1'b1; e.code = 2'b11; e.done_cyc = acc;
    end else if (align && ((addr_i % nbytes) != 0)) begin
      e.fault = 1'b1; e.code = 2'b01; e.done_cyc = acc;
    end else begin
      wa = addr_i & 32'hFFFF_FFFC;
      if (wa[31:16] != 16'h1000) begin
        e.fault = 1'b1; e.code = 2'b10; e.done_cyc = acc + 1;
      end else begin
        word  = model_mem.exists(wa) ? model_mem[wa] : 32'h0;
        off   = int'(addr_i[1:0]) - (int'(addr_i[1:0]) % nbytes);
        shift = 8 * (4 - nbytes - off);
        lmask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        mask  = lmask << shift;
        if (!rw_i) begin
          val = (word >> shift) & lmask;
          if (sgn_i && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~lmask;
          e.rdata    = val;
          e.done_cyc = acc + 1;
        end else begin
          e.we_cyc   = acc + 1;
          e.we_addr  = wa;
          e.we_data  = (word & ~mask) | ((wdata_i << shift) & mask);
          e.done_cyc = acc + 2;
        end
      end
    end
    return e;
  endfunction

  // Per-cycle comparison against the model queue.
  always @(negedge clk) begin
    bit   exp_done, exp_we, busy;
    if (reset) begin
      checkOutput("rst_ready", {31'h0, ready}, 32'h1);
      checkOutput("rst_done", {31'h0, done}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_fault", {31'h0, fault}, 32'h0);
      checkOutput("rst_code", {30'h0, fault_code}, 32'h0);
      checkOutput("rst_mem_addr", mem_addr, 32'h0);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      checkOutput("rst_mem_we", {31'h0, mem_we}, 32'h0);
      exp_q.delete();
    end else begin
      exp_done = (exp_q.size() > 0) && (exp_q[0].done_cyc == cyc);
      exp_we   = (exp_q.size() > 0) && (exp_q[0].we_cyc == cyc);
      busy     = (exp_q.size() > 0) && (exp_q[0].acc_cyc <= cyc);
      checkOutput("ready", {31'h0, ready}, {31'h0, !busy});
      checkOutput("done", {31'h0, done}, {31'h0, exp_done});
      checkOutput("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
      if (exp_we) begin
        checkOutput("mem_addr", mem_addr, exp_q[0].we_addr);
        checkOutput("mem_wdata", mem_wdata, exp_q[0].we_data);
      end
      if (exp_done) begin
        checkOutput("rdata", rdata, exp_q[0].rdata);
        checkOutput("fault", {31'h0, fault}, {31'h0, exp_q[0].fault});
        checkOutput("fault_code", {30'h0, fault_code}, {30'h0, exp_q[0].code});
        if (exp_q[0].we_cyc >= 0) model_mem[exp_q[0].we_addr] = exp_q[0].we_data;
        void'(exp_q.pop_front());
      end
    end
    if (done) begin
      done_count++;
      last_done_cyc = cyc;
      last_rdata    = rdata;
      last_fault    = fault;
      last_code     = fault_code;
    end
    if (mem_we) begin
      we_count++;
      last_we_cyc  = cyc;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
    if (done1) begin
      last1_done_cyc = cyc;
      last1_rdata    = rdata1;
      last1_fault    = fault1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    model_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drive one request for a single cycle; acc is the cycle count right
  // after the accepting edge.
  task automatic applyStimulus(input logic rw_i, input logic [1:0] size_i,
                               input logic sgn_i, input logic [31:0] addr_i,
                               input logic [31:0] wdata_i, output int acc);
    @(negedge clk);
    acc = cyc + 1;
    rw = rw_i; size = size_i; signed_ld = sgn_i; addr = addr_i; wdata = wdata_i;
    req = 1'b1;
    exp_q.push_back(model_req(rw_i, size_i, sgn_i, addr_i, wdata_i, acc, 1'b1));
    @(negedge clk);
    req = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] result;
  } load_vec_t;

  initial begin
    int acc, acc2, dc;
    load_vec_t lv[7];
    lv[0] = '{2'b00, 1'b1, 32'h1000_0008, 32'hFFFF_FF80};
    lv[1] = '{2'b00, 1'b0, 32'h1000_0009, 32'h0000_00FF};
    lv[2] = '{2'b00, 1'b1, 32'h1000_000A, 32'h0000_007F};
    lv[3] = '{2'b00, 1'b1, 32'h1000_000B, 32'h0000_0001};
    lv[4] = '{2'b01, 1'b1, 32'h1000_0008, 32'hFFFF_80FF};
    lv[5] = '{2'b01, 1'b0, 32'h1000_000A, 32'h0000_7F01};
    lv[6] = '{2'b10, 1'b0, 32'h1000_0008, 32'h80FF_7F01};

    reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; signed_ld = 1'b0;
    addr = 32'h0; wdata = 32'h0; bd_we = 1'b0; bd_addr = 32'h0; bd_data = 32'h0;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Byte store read-modify-write.
    set_word(32'h1000_0000, 32'h1122_3344);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000_0001, 32'h0000_00AB, acc);
    idle(5);
    checkOutput("bst_mem", mem_arr[0], 32'h11AB_3344);
    checkOutput("bst_we_cyc", last_we_cyc, acc + 1);
    checkOutput("bst_we_addr", last_we_addr, 32'h1000_0000);
    checkOutput("bst_we_data", last_we_data, 32'h11AB_3344);
    checkOutput("bst_done_cyc", last_done_cyc, acc + 2);
    checkOutput("bst_fault", {31'h0, last_fault}, 32'h0);

    // Halfword loads, signed and unsigned.
    set_word(32'h1000_0000, 32'h1122_F0F0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h1000_0002, 32'h0, acc);
    idle(4);
    checkOutput("hld_s_rdata", last_rdata, 32'hFFFF_F0F0);
    checkOutput("hld_s_cyc", last_done_cyc, acc + 1);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h1000_0002, 32'h0, acc);
    idle(4);
    checkOutput("hld_u_rdata", last_rdata, 32'h0000_F0F0);
    checkOutput("hld_u_cyc", last_done_cyc, acc + 1);

    // Misaligned word load; the ALIGN_CHECK=0 instance reads the word.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_0002, 32'h0, acc);
    idle(5);
    checkOutput("mis_cyc", last_done_cyc, acc);
    checkOutput("mis_fault", {31'h0, last_fault}, 32'h1);
    checkOutput("mis_code", {30'h0, last_code}, 32'h1);
    checkOutput("noal_cyc", last1_done_cyc, acc + 1);
    checkOutput("noal_rdata", last1_rdata, 32'h1122_F0F0);
    checkOutput("noal_fault", {31'h0, last1_fault}, 32'h0);

    // Lane extraction table.
    set_word(32'h1000_0008, 32'h80FF_7F01);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, lv[i].sz, lv[i].sgn, lv[i].a, 32'h0, acc);
      idle(4);
      checkOutput($sformatf("ld_tab%0d", i), last_rdata, lv[i].result);
    end

    // Out-of-region store and illegal size.
    dc = we_count;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h2000_0000, 32'h0000_0077, acc);
    idle(5);
    checkOutput("oor_cyc", last_done_cyc, acc + 1);
    checkOutput("oor_code", {30'h0, last_code}, 32'h2);
    checkOutput("oor_no_we", we_count, dc);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h1000_0003, 32'h0, acc);
    idle(4);
    checkOutput("ill_cyc", last_done_cyc, acc);
    checkOutput("ill_code", {30'h0, last_code}, 32'h3);

    // Reset in the middle of WRITE.
    set_word(32'h1000_0004, 32'hCAFE_BABE);
    dc = done_count;
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000_0004, 32'h0000_0055, acc);
    @(negedge clk);
    checkOutput("rw_we_before", {31'h0, mem_we}, 32'h1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rw_we_drop", {31'h0, mem_we}, 32'h0);
    checkOutput("rw_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    idle(4);
    checkOutput("rw_mem", mem_arr[1], 32'hCAFE_BABE);
    checkOutput("rw_no_done", done_count, dc);

    // Back-to-back with req held: word load, then halfword store.
    @(negedge clk);
    acc = cyc + 1;
    rw = 1'b0; size = 2'b10; signed_ld = 1'b0; addr = 32'h1000_0000; wdata = 32'h0;
    req = 1'b1;
    exp_q.push_back(model_req(1'b0, 2'b10, 1'b0, 32'h1000_0000, 32'h0, acc, 1'b1));
    @(negedge clk);
    acc2 = acc + 3;
    rw = 1'b1; size = 2'b01; addr = 32'h1000_0006; wdata = 32'h0000_BEEF;
    exp_q.push_back(model_req(1'b1, 2'b01, 1'b0, 32'h1000_0006, 32'h0000_BEEF, acc2, 1'b1));
    repeat (3) @(negedge clk);
    req = 1'b0;
    idle(5);
    checkOutput("b2b_mem", mem_arr[1], 32'hCAFE_BEEF);
    checkOutput("b2b_done_cyc", last_done_cyc, acc + 5);

    checkOutput("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
